rotary_field_editor: RTL and testbench

Sequencing controller that shares one debounced rotary encoder and one push button among NUM_FIELDS parameter registers. In browse mode, encoder steps move a field selector. A button press enters edit mode, where steps adjust a saturating edit value. A short press commits the value to a downstream register file through a valid/ready write port; a long press cancels the edit. The block sits between the encoder step logic and the CPU-visible configuration registers, and keeps a shadow copy of every field.

---
 rtl/rotary_field_editor.sv | 125 ++++++++++++
 tb/tb_rotary_field_editor.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rotary_field_editor.sv
// Rotary encoder / push-button editor for a bank of shadowed parameter fields.
// Browse with the encoder, press to edit, short press commits, long press cancels.
//
// state | meaning
// IDLE  | browsing; steps move the field selector
// EDIT  | steps adjust the saturating edit value
// PRESS | button held after an edit; timing short vs long press
// WRITE | commit presented on the write port until accepted
module rotary_field_editor #(
  parameter int NUM_FIELDS  = 4,
  parameter int WIDTH       = 8,
  parameter int MAX_VAL     = 255,
  parameter int RESET_VAL   = 0,
  parameter int HOLD_CYCLES = 1000,
  localparam int IDX_W = ($clog2(NUM_FIELDS) > 1) ? $clog2(NUM_FIELDS) : 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        step_en,
  input  logic                        step_up,
  input  logic                        btn,
  output logic [IDX_W-1:0]            sel_idx,
  output logic [WIDTH-1:0]            edit_val,
  output logic                        editing,
  output logic                        wr_valid,
  input  logic                        wr_ready,
  output logic [IDX_W-1:0]            wr_idx,
  output logic [WIDTH-1:0]            wr_data,
  output logic [NUM_FIELDS*WIDTH-1:0] fields
);

  localparam int HW = $clog2(HOLD_CYCLES) + 1;

  typedef enum logic [1:0] {IDLE, EDIT, PRESS, WRITE} state_t;

  state_t            state_q, state_d;
  logic              btn_q;
  logic [IDX_W-1:0]  sel_q, sel_d;
  logic [WIDTH-1:0]  edit_q, edit_d;
  logic [HW-1:0]     hold_q, hold_d;
  logic [WIDTH-1:0]  fields_q [NUM_FIELDS];
  logic [WIDTH-1:0]  fields_d [NUM_FIELDS];
  logic              press;

  assign press = btn & ~btn_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      btn_q   <= 1'b0;
      sel_q   <= '0;
      edit_q  <= '0;
      hold_q  <= '0;
      for (int i = 0; i < NUM_FIELDS; i++) fields_q[i] <= WIDTH'(RESET_VAL);
    end else begin
      state_q <= state_d;
      btn_q   <= btn;
      sel_q   <= sel_d;
      edit_q  <= edit_d;
      hold_q  <= hold_d;
      for (int i = 0; i < NUM_FIELDS; i++) fields_q[i] <= fields_d[i];
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    edit_d  = edit_q;
    hold_d  = hold_q;
    for (int i = 0; i < NUM_FIELDS; i++) fields_d[i] = fields_q[i];

    case (state_q)
      IDLE: begin
        // A press takes priority over a simultaneous detent.
        if (press) begin
          edit_d  = fields_q[sel_q];
          state_d = EDIT;
        end else if (step_en) begin
          if (step_up)
            sel_d = (sel_q == IDX_W'(NUM_FIELDS - 1)) ? '0 : sel_q + IDX_W'(1);
          else
            sel_d = (sel_q == '0) ? IDX_W'(NUM_FIELDS - 1) : sel_q - IDX_W'(1);
        end
      end
      EDIT: begin
        if (press) begin
          hold_d  = '0;
          state_d = PRESS;
        end else if (step_en) begin
          if (step_up && edit_q != WIDTH'(MAX_VAL))
            edit_d = edit_q + WIDTH'(1);
          else if (!step_up && edit_q != '0)
            edit_d = edit_q - WIDTH'(1);
        end
      end
      PRESS: begin
        if (!btn)
          state_d = WRITE;
        else if (hold_q >= HW'(HOLD_CYCLES - 1))
          state_d = IDLE;
        else
          hold_d = hold_q + HW'(1);
      end
      WRITE: begin
        if (wr_ready) begin
          fields_d[sel_q] = edit_q;
          state_d         = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign sel_idx  = sel_q;
  assign edit_val = edit_q;
  assign editing  = (state_q != IDLE);
  assign wr_valid = (state_q == WRITE);
  assign wr_idx   = sel_q;
  assign wr_data  = edit_q;

  for (genvar g = 0; g < NUM_FIELDS; g++) begin : g_fields
    assign fields[g*WIDTH +: WIDTH] = fields_q[g];
  end

endmodule

// File: tb/tb_rotary_field_editor.sv
// Randomized scoreboard bench for rotary_field_editor against a transaction-level
// model of selector, edit value, shadow fields and expected commits.
module tb_rotary_field_editor;
  localparam int NF   = 4;
  localparam int W    = 8;
  localparam int MAXV = 255;
  localparam int RV   = 0;
  localparam int HOLD = 20;
  localparam int IW   = 2;

  logic clk = 1'b0;
  logic reset, step_en, step_up, btn, wr_ready;
  logic [IW-1:0]   sel_idx, wr_idx;
  logic [W-1:0]    edit_val, wr_data;
  logic            editing, wr_valid;
  logic [NF*W-1:0] fields;

  rotary_field_editor #(.NUM_FIELDS(NF), .WIDTH(W), .MAX_VAL(MAXV),
                        .RESET_VAL(RV), .HOLD_CYCLES(HOLD)) dut (
    .clk(clk), .reset(reset), .step_en(step_en), .step_up(step_up), .btn(btn),
    .sel_idx(sel_idx), .edit_val(edit_val), .editing(editing),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_idx(wr_idx), .wr_data(wr_data),
    .fields(fields)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  int m_sel;
  int m_edit;
  bit m_editing;
  int m_fields [NF];

  typedef struct { int idx; int data; } wr_t;
  wr_t exp_q[$];

  task automatic chk(input string name, input int act, input int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, expv, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_sel"}, int'(sel_idx), m_sel);
    chk({tag, "_editing"}, int'(editing), int'(m_editing));
    if (m_editing) chk({tag, "_edit_val"}, int'(edit_val), m_edit);
  endtask

  task automatic check_fields(input string tag);
    for (int i = 0; i < NF; i++)
      chk($sformatf("%s_field%0d", tag, i), int'(fields[i*W +: W]), m_fields[i]);
  endtask

  task automatic model_reset();
    m_sel = 0; m_edit = 0; m_editing = 0;
    for (int i = 0; i < NF; i++) m_fields[i] = RV;
  endtask

  task automatic step(input bit up);
    step_en = 1'b1; step_up = up;
    tick();
    step_en = 1'b0;
    if (!m_editing) m_sel = up ? (m_sel + 1) % NF : (m_sel + NF - 1) % NF;
    else if (up)    m_edit = (m_edit < MAXV) ? m_edit + 1 : MAXV;
    else            m_edit = (m_edit > 0) ? m_edit - 1 : 0;
    check_state("step");
  endtask

  task automatic enter(input bit with_step);
    btn = 1'b1; step_en = with_step; step_up = 1'($urandom_range(0, 1));
    tick();
    step_en = 1'b0;
    m_edit = m_fields[m_sel]; m_editing = 1'b1;
    check_state("enter");
    btn = 1'b0;
    tick();
    check_state("enter_rel");
  endtask

  task automatic commit(input int hold_n, input int delay, input bit noise, input bit early);
    btn = 1'b1; wr_ready = 1'b0;
    tick();
    chk("press_editing", int'(editing), 1);
    for (int h = 0; h < hold_n; h++) begin
      step_en = noise ? 1'($urandom_range(0, 1)) : 1'b0; step_up = 1'($urandom_range(0, 1));
      tick();
    end
    step_en = 1'b0; btn = 1'b0;
    if (early) wr_ready = 1'b1;
    tick();
    exp_q.push_back('{m_sel, m_edit});
    chk("rel_wr_valid", int'(wr_valid), 1);
    for (int d = 0; d < delay; d++) begin
      step_en = noise ? 1'($urandom_range(0, 1)) : 1'b0; step_up = 1'($urandom_range(0, 1));
      btn = (noise && d < delay - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      tick();
      chk("wait_wr_valid", int'(wr_valid), 1);
      chk("wait_wr_idx", int'(wr_idx), m_sel);
      chk("wait_wr_data", int'(wr_data), m_edit);
      check_fields("wait");
    end
    step_en = 1'b0; btn = 1'b0; wr_ready = 1'b1;
    tick();
    wr_ready = 1'b0;
    m_fields[m_sel] = m_edit; m_editing = 1'b0;
    chk("post_wr_valid", int'(wr_valid), 0);
    check_state("commit");
    check_fields("commit");
  endtask

  task automatic cancel();
    btn = 1'b1;
    tick();
    repeat (HOLD + 5) tick();
    m_editing = 1'b0;
    chk("cancel_wr_valid", int'(wr_valid), 0);
    check_state("cancel");
    btn = 1'b0;
    tick(); tick();
    check_state("cancel_rel");
    check_fields("cancel");
  endtask

  // Monitor: every accepted write must match the oldest expected commit.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset && wr_valid) begin
        if (exp_q.size() == 0) chk("unexpected_wr_valid", 1, 0);
        else if (wr_ready) begin
          wr_t e;
          e = exp_q.pop_front();
          chk("sb_wr_idx", int'(wr_idx), e.idx);
          chk("sb_wr_data", int'(wr_data), e.data);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; step_en = 1'b0; step_up = 1'b0; btn = 1'b0; wr_ready = 1'b0;
    model_reset();
    tick(); tick();
    reset = 1'b0;
    tick();
    check_state("reset");
    check_fields("reset");
    chk("reset_wr_valid", int'(wr_valid), 0);

    // Selector wrap both ways.
    repeat (5) step(1'b1);
    repeat (2) step(1'b0);
    step(1'b0);

    // Basic commit of 3 into field 2.
    enter(1'b0);
    repeat (3) step(1'b1);
    commit(9, 0, 1'b0, 1'b0);

    // Saturation at both limits on field 1.
    step(1'b0);
    enter(1'b0);
    repeat (260) step(1'b0);
    repeat (254) step(1'b1);
    commit(0, 0, 1'b0, 1'b0);
    enter(1'b0);
    repeat (4) step(1'b1);
    cancel();
    step(1'b0);
    enter(1'b0);
    repeat (2) step(1'b0);
    cancel();

    // Long press cancel with edit value 7 on field 3.
    step(1'b0);
    enter(1'b0);
    repeat (7) step(1'b1);
    cancel();

    // Back-pressured commit with noise during the wait.
    enter(1'b0);
    step(1'b1);
    commit(3, 6, 1'b1, 1'b0);

    // Press and step in the same IDLE cycle: press wins.
    enter(1'b1);
    cancel();

    for (int it = 0; it < 30; it++) begin
      int n, k;
      bit early;
      n = $urandom_range(0, 4);
      for (int s = 0; s < n; s++) step(1'($urandom_range(0, 1)));
      enter(($urandom_range(0, 7) == 0));
      k = $urandom_range(0, 8);
      for (int s = 0; s < k; s++) step(1'($urandom_range(0, 1)));
      if ($urandom_range(0, 4) == 0) cancel();
      else begin
        early = ($urandom_range(0, 3) == 0);
        commit($urandom_range(0, HOLD - 2), early ? 0 : $urandom_range(0, 5), 1'b1, early);
      end
    end

    // Reset while a commit is pending.
    enter(1'b0);
    step(1'b1);
    btn = 1'b1; tick();
    btn = 1'b0; tick();
    chk("pre_reset_wr_valid", int'(wr_valid), 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_q.delete();
    model_reset();
    chk("reset_abort_wr_valid", int'(wr_valid), 0);
    check_state("reset_abort");
    check_fields("reset_abort");
    tick();
    chk("reset_abort_wr_valid2", int'(wr_valid), 0);

    chk("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
